// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - serial-in parallel-out deserializer with valid/ready holding register
//
// Purpose: collects one serial bit per enabled cycle into a WIDTH-bit word and
// hands each completed word to a one-entry holding register on a valid/ready
// parallel port. frame_start realigns word boundaries; a sticky overrun flag
// records completed words dropped while the holding register was occupied.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   serial_in    serial data bit, sampled only when serial_en=1
//   serial_en    serial bit qualifier
//   frame_start  with serial_en, makes the current bit bit 0 of a new word
//   par_data     held word, stable while par_valid=1
//   par_valid    holding register contains an unconsumed word
//   par_ready    consumer accepts the word when par_valid && par_ready
//   overrun      sticky: a completed word was dropped
//   overrun_clr  synchronous clear of overrun (a new drop wins)
//   busy         a partial word is in progress

module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  input  logic             serial_en,
  input  logic             frame_start,
  output logic [WIDTH-1:0] par_data,
  output logic             par_valid,
  input  logic             par_ready,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             busy
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] fresh;
  logic             complete;
  logic             hold_free;

  // shifted: the register advanced by the current bit; fresh: a new word whose
  // only content is the current bit in the bit-0 position.
  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {shift_q[WIDTH-2:0], serial_in};
      assign fresh   = {{(WIDTH-1){1'b0}}, serial_in};
    end else begin : g_lsb
      assign shifted = {serial_in, shift_q[WIDTH-1:1]};
      assign fresh   = {serial_in, {(WIDTH-1){1'b0}}};
    end
  endgenerate

  // Completion looks at the count before frame_start is applied, so a
  // frame_start on the last bit still completes the pending word.
  assign complete  = serial_en && (count_q == LAST);
  assign hold_free = !valid_q || par_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (serial_en) begin
          shift_d = fresh;
          count_d = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (serial_en) begin
          if (complete) begin
            shift_d = shifted;
            count_d = '0;
            state_d = IDLE;
          end else if (frame_start) begin
            shift_d = fresh;
            count_d = CW'(1);
          end else begin
            shift_d = shifted;
            count_d = count_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (valid_q && par_ready) begin
      valid_d = 1'b0;
    end
    if (overrun_clr) begin
      ovr_d = 1'b0;
    end
    // A drop is evaluated after the clear so it takes priority.
    if (complete) begin
      if (hold_free) begin
        data_d  = shifted;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign par_data  = data_q;
  assign par_valid = valid_q;
  assign overrun   = ovr_q;
  assign busy      = (count_q != '0);

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb/tb_sipo_deserializer.sv - scoreboard bench for sipo_deserializer, MSB-first and LSB-first instances

module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       serial_in, serial_en, frame_start, par_ready, overrun_clr;
  logic [7:0] data_m, data_l;
  logic       valid_m, valid_l, ovr_m, ovr_l, busy_m, busy_l;

  int checks = 0;
  int errors = 0;
  logic [7:0] q_m[$];
  logic [7:0] q_l[$];

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .serial_en(serial_en),
    .frame_start(frame_start), .par_data(data_m), .par_valid(valid_m),
    .par_ready(par_ready), .overrun(ovr_m), .overrun_clr(overrun_clr), .busy(busy_m)
  );

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .serial_en(serial_en),
    .frame_start(frame_start), .par_data(data_l), .par_valid(valid_l),
    .par_ready(par_ready), .overrun(ovr_l), .overrun_clr(overrun_clr), .busy(busy_l)
  );

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected words: the MSB-first instance sees the word as sent, the
  // LSB-first instance sees it bit-reversed.
  task automatic expect_word(input logic [7:0] w);
    q_m.push_back(w);
    q_l.push_back(rev8(w));
  endtask

  // Monitor: every handshake (valid && ready) seen mid-cycle pops one word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_m && par_ready) begin
        if (q_m.size() == 0) chk("sb_msb_unexpected", {24'd0, data_m}, 32'hFFFF_FFFF);
        else chk("sb_msb_word", {24'd0, data_m}, {24'd0, q_m.pop_front()});
      end
      if (valid_l && par_ready) begin
        if (q_l.size() == 0) chk("sb_lsb_unexpected", {24'd0, data_l}, 32'hFFFF_FFFF);
        else chk("sb_lsb_word", {24'd0, data_l}, {24'd0, q_l.pop_front()});
      end
    end
  end

  task automatic send_bit(input logic b, input logic fs);
    serial_in   = b;
    serial_en   = 1'b1;
    frame_start = fs;
    @(posedge clk);
    #1;
    serial_en   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends the first nbits of w, MSB of w first. fs_at selects the bit that
  // carries frame_start (-1: none). gapped inserts a disabled cycle after each
  // bit with junk data and frame_start asserted, which must be ignored.
  task automatic send_word(input logic [7:0] w, input int nbits, input bit gapped,
                           input int fs_at, input bit flags);
    for (int i = 0; i < nbits; i++) begin
      send_bit(w[7-i], (i == fs_at));
      if (flags) begin
        chk("busy_msb", {31'd0, busy_m}, {31'd0, (i < 7)});
        chk("busy_lsb", {31'd0, busy_l}, {31'd0, (i < 7)});
        chk("valid_msb", {31'd0, valid_m}, {31'd0, (i == 7)});
        chk("valid_lsb", {31'd0, valid_l}, {31'd0, (i == 7)});
      end
      if (gapped) begin
        serial_in   = ~w[7-i];
        frame_start = 1'b1;
        idle(1);
        frame_start = 1'b0;
        if (flags && i < 7) begin
          chk("gap_busy", {31'd0, busy_l}, 32'd1);
          chk("gap_valid", {31'd0, valid_l}, 32'd0);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; serial_in = 1'b0; serial_en = 1'b0; frame_start = 1'b0;
    par_ready = 1'b0; overrun_clr = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    chk("rst_data", {24'd0, data_m}, 32'd0);
    chk("rst_valid", {31'd0, valid_m}, 32'd0);
    chk("rst_ovr", {31'd0, ovr_m}, 32'd0);
    chk("rst_busy", {31'd0, busy_m}, 32'd0);

    // Basic word with ready held.
    par_ready = 1'b1;
    expect_word(8'hA5);
    send_word(8'hA5, 8, 1'b0, -1, 1'b1);
    idle(1);
    chk("basic_valid_one_cycle", {31'd0, valid_m}, 32'd0);

    // Gapped input.
    expect_word(8'hA5);
    send_word(8'hA5, 8, 1'b1, -1, 1'b1);
    chk("gap_after_valid", {31'd0, valid_m}, 32'd0);

    // Stall: second word dropped, then overrun set beats clear.
    par_ready = 1'b0;
    expect_word(8'h3C);
    send_word(8'h3C, 8, 1'b0, -1, 1'b0);
    chk("stall_ovr_before", {31'd0, ovr_m}, 32'd0);
    send_word(8'hC3, 8, 1'b0, -1, 1'b0);
    chk("stall_ovr", {31'd0, ovr_m}, 32'd1);
    chk("stall_ovr_lsb", {31'd0, ovr_l}, 32'd1);
    chk("stall_data", {24'd0, data_m}, 32'h3C);
    send_word(8'h0F, 7, 1'b0, -1, 1'b0);
    overrun_clr = 1'b1;
    send_bit(1'b1, 1'b0);
    overrun_clr = 1'b0;
    chk("ovr_set_priority", {31'd0, ovr_m}, 32'd1);
    chk("stall_data_kept", {24'd0, data_m}, 32'h3C);
    par_ready = 1'b1;
    idle(1);
    par_ready = 1'b0;
    chk("stall_valid_drop", {31'd0, valid_m}, 32'd0);
    chk("stall_ovr_kept", {31'd0, ovr_m}, 32'd1);
    overrun_clr = 1'b1;
    idle(1);
    overrun_clr = 1'b0;
    chk("ovr_clr", {31'd0, ovr_m}, 32'd0);

    // Simultaneous consume and complete.
    expect_word(8'h11);
    send_word(8'h11, 8, 1'b0, -1, 1'b0);
    send_word(8'h22, 7, 1'b0, -1, 1'b0);
    par_ready = 1'b1;
    expect_word(8'h22);
    send_bit(1'b0, 1'b0);
    chk("simul_valid", {31'd0, valid_m}, 32'd1);
    chk("simul_data", {24'd0, data_m}, 32'h22);
    chk("simul_data_lsb", {24'd0, data_l}, 32'h44);
    chk("simul_ovr", {31'd0, ovr_m}, 32'd0);
    idle(1);
    chk("simul_drain", {31'd0, valid_m}, 32'd0);

    // Resync with frame_start, then frame_start on the final bit.
    send_word(8'hE0, 3, 1'b0, -1, 1'b0);
    chk("resync_busy", {31'd0, busy_m}, 32'd1);
    expect_word(8'h5A);
    send_word(8'h5A, 8, 1'b0, 0, 1'b0);
    chk("resync_ovr", {31'd0, ovr_m}, 32'd0);
    expect_word(8'h96);
    send_word(8'h96, 8, 1'b0, 7, 1'b0);
    chk("fs_last_busy", {31'd0, busy_m}, 32'd0);
    expect_word(8'h33);
    send_word(8'h33, 8, 1'b0, -1, 1'b0);
    idle(2);

    // Asynchronous reset mid-word with a held word and overrun set.
    par_ready = 1'b0;
    expect_word(8'h77);
    send_word(8'h77, 8, 1'b0, -1, 1'b0);
    send_word(8'h01, 8, 1'b0, -1, 1'b0);
    send_word(8'h55, 5, 1'b0, -1, 1'b0);
    chk("pre_rst_busy", {31'd0, busy_m}, 32'd1);
    chk("pre_rst_ovr", {31'd0, ovr_m}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, valid_m}, 32'd0);
    chk("arst_busy", {31'd0, busy_m}, 32'd0);
    chk("arst_ovr", {31'd0, ovr_m}, 32'd0);
    chk("arst_data", {24'd0, data_m}, 32'd0);
    chk("arst_data_lsb", {24'd0, data_l}, 32'd0);
    q_m.delete();
    q_l.delete();
    idle(1);
    rst_n = 1'b1;
    par_ready = 1'b1;
    expect_word(8'hFF);
    send_word(8'hFF, 8, 1'b0, -1, 1'b0);
    chk("post_rst_data", {24'd0, data_m}, 32'hFF);
    idle(2);

    chk("sb_drain_msb", q_m.size(), 32'd0);
    chk("sb_drain_lsb", q_l.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
